// File: rtl/tdc_phase_detector.sv
// tdc_phase_detector
// Counter-based phase detector for the CDR loop. It timestamps a selected
// d_in transition, measures the clk-cycle distance to the next recovered_clk
// rising edge, and subtracts EXPECTED_DELAY. The result is a saturated signed
// error with a valid strobe. Miss detection and a lock indicator are included.
//
// Optional feature macro: TDC_PD_STATS_EN
//   defined   -> valid_count / miss_count are saturating 16-bit event counters
//   undefined -> valid_count / miss_count are tied to zero
//
// Handshake: err_valid and miss are single-cycle strobes with no back-pressure.
// phase_error and saturated are valid in the cycle err_valid is high and hold
// their value until the next err_valid.
module tdc_phase_detector #(
  parameter int CNT_W          = 8,
  parameter int ERR_W          = 6,
  parameter int EXPECTED_DELAY = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_WIN       = 1,
  parameter int LOCK_CNT       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    d_in,
  input  logic                    recovered_clk,
  input  logic [1:0]              edge_mode,
  output logic signed [ERR_W-1:0] phase_error,
  output logic                    err_valid,
  output logic                    saturated,
  output logic                    miss,
  output logic                    locked,
  output logic [15:0]             valid_count,
  output logic [15:0]             miss_count
);

  // The raw error is delta - EXPECTED_DELAY. It always fits in CNT_W+1 signed bits.
  localparam int EW  = CNT_W + 1;
  localparam int LCW = $clog2(LOCK_CNT + 1);

  localparam logic signed [EW-1:0] ERR_MAX = EW'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [EW-1:0] ERR_MIN = EW'(-(2 ** (ERR_W - 1)));
  localparam logic signed [EW-1:0] EXP_S   = EW'(EXPECTED_DELAY);
  localparam logic signed [EW-1:0] WIN_HI  = EW'(LOCK_WIN);
  localparam logic signed [EW-1:0] WIN_LO  = EW'(-LOCK_WIN);
  localparam logic [LCW-1:0]       LOCK_TOP = LCW'(LOCK_CNT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Registered state
  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   d_sync_q, d_sync_d;
  logic [SYNC_STAGES-1:0]   rc_sync_q, rc_sync_d;
  logic                     d_prev_q, d_prev_d;
  logic                     rc_prev_q, rc_prev_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         d_time_q, d_time_d;
  logic signed [ERR_W-1:0]  phase_error_q, phase_error_d;
  logic                     saturated_q, saturated_d;
  logic                     err_valid_q, err_valid_d;
  logic                     miss_q, miss_d;
  logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;
  logic                     locked_q, locked_d;

  // Combinational helpers
  logic                     d_last, rc_last;
  logic                     d_rise, d_fall;
  logic                     data_edge, ref_edge;
  logic [CNT_W-1:0]         delta;
  logic signed [EW-1:0]     err_raw;
  logic signed [ERR_W-1:0]  err_clamped;
  logic                     err_sat;
  logic                     in_win;

  // Edge detection on the last synchroniser stage against its one-cycle-delayed copy
  always_comb begin
    d_last  = d_sync_q[SYNC_STAGES-1];
    rc_last = rc_sync_q[SYNC_STAGES-1];
    d_rise  = d_last & ~d_prev_q;
    d_fall  = ~d_last & d_prev_q;
    ref_edge = rc_last & ~rc_prev_q;
    case (edge_mode)
      2'b01:   data_edge = d_fall;
      2'b10:   data_edge = d_rise | d_fall;
      default: data_edge = d_rise;
    endcase
  end

  // Error computation: modulo delta, offset removal, clamp and lock-window test
  always_comb begin
    // A coincident data edge restarts the measurement, so the delta is zero.
    delta   = data_edge ? '0 : (cnt_q - d_time_q);
    err_raw = $signed({1'b0, delta}) - EXP_S;
    err_sat = 1'b0;
    if (err_raw > ERR_MAX) begin
      err_clamped = ERR_MAX[ERR_W-1:0];
      err_sat     = 1'b1;
    end else if (err_raw < ERR_MIN) begin
      err_clamped = ERR_MIN[ERR_W-1:0];
      err_sat     = 1'b1;
    end else begin
      err_clamped = err_raw[ERR_W-1:0];
    end
    // The lock window uses the pre-clamp error.
    in_win = (err_raw >= WIN_LO) && (err_raw <= WIN_HI);
  end

  // Next-state logic for the synchronisers, the timestamp counter, the FSM and the lock tracker
  always_comb begin
    d_sync_d      = {d_sync_q[SYNC_STAGES-2:0], d_in};
    rc_sync_d     = {rc_sync_q[SYNC_STAGES-2:0], recovered_clk};
    d_prev_d      = d_last;
    rc_prev_d     = rc_last;
    cnt_d         = cnt_q + CNT_W'(1);
    state_d       = state_q;
    d_time_d      = d_time_q;
    phase_error_d = phase_error_q;
    saturated_d   = saturated_q;
    err_valid_d   = 1'b0;
    miss_d        = 1'b0;
    lock_cnt_d    = lock_cnt_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
    end else if (ref_edge && (data_edge || (state_q == ST_ARMED))) begin
      err_valid_d   = 1'b1;
      phase_error_d = err_clamped;
      saturated_d   = err_sat;
      state_d       = ST_IDLE;
      if (!in_win) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_TOP) begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end else if (ref_edge) begin
      // A reference edge with no timestamp armed is a miss.
      miss_d     = 1'b1;
      lock_cnt_d = '0;
    end else if (data_edge) begin
      d_time_d = cnt_q;
      state_d  = ST_ARMED;
    end

    locked_d = (lock_cnt_d == LOCK_TOP);
  end

  // Single register bank for the FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      d_sync_q      <= '0;
      rc_sync_q     <= '0;
      d_prev_q      <= 1'b0;
      rc_prev_q     <= 1'b0;
      cnt_q         <= '0;
      d_time_q      <= '0;
      phase_error_q <= '0;
      saturated_q   <= 1'b0;
      err_valid_q   <= 1'b0;
      miss_q        <= 1'b0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_sync_q      <= d_sync_d;
      rc_sync_q     <= rc_sync_d;
      d_prev_q      <= d_prev_d;
      rc_prev_q     <= rc_prev_d;
      cnt_q         <= cnt_d;
      d_time_q      <= d_time_d;
      phase_error_q <= phase_error_d;
      saturated_q   <= saturated_d;
      err_valid_q   <= err_valid_d;
      miss_q        <= miss_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign phase_error = phase_error_q;
  assign saturated   = saturated_q;
  assign err_valid   = err_valid_q;
  assign miss        = miss_q;
  assign locked      = locked_q;

`ifdef TDC_PD_STATS_EN
  logic [15:0] valid_count_q, valid_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating event counters, advanced together with the strobes they count
  always_comb begin
    valid_count_d = valid_count_q;
    miss_count_d  = miss_count_q;
    if (err_valid_d && (valid_count_q != 16'hFFFF)) valid_count_d = valid_count_q + 16'd1;
    if (miss_d && (miss_count_q != 16'hFFFF))       miss_count_d  = miss_count_q + 16'd1;
  end

  // Stats registers are cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_count_q <= '0;
      miss_count_q  <= '0;
    end else begin
      valid_count_q <= valid_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign valid_count = valid_count_q;
  assign miss_count  = miss_count_q;
`else
  assign valid_count = '0;
  assign miss_count  = '0;
`endif

endmodule

// File: tb/tb_tdc_phase_detector.sv
// Testbench for tdc_phase_detector (default parameters).
// Table vectors and hand sequences cover the listed corner cases. Random pin
// activity is checked against an event-level model that works in bench cycle
// numbers, and every err_valid/miss strobe is compared in order by a scoreboard.
module tb_tdc_phase_detector;

  localparam int CNT_W    = 8;
  localparam int ERR_W    = 6;
  localparam int EXP_D    = 5;
  localparam int SYNC     = 2;
  localparam int LOCK_WIN = 1;
  localparam int LOCK_CNT = 8;
  localparam int ERR_HI   = (1 << (ERR_W - 1)) - 1;
  localparam int ERR_LO   = -(1 << (ERR_W - 1));
  localparam int PW       = ERR_W + 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, enable, d_in, recovered_clk;
  logic [1:0] edge_mode;
  logic signed [ERR_W-1:0] phase_error;
  logic err_valid, saturated, miss, locked;
  logic [15:0] valid_count, miss_count;

  always #5 clk = ~clk;

  tdc_phase_detector #(
    .CNT_W(CNT_W), .ERR_W(ERR_W), .EXPECTED_DELAY(EXP_D),
    .SYNC_STAGES(SYNC), .LOCK_WIN(LOCK_WIN), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
    .recovered_clk(recovered_clk), .edge_mode(edge_mode),
    .phase_error(phase_error), .err_valid(err_valid), .saturated(saturated),
    .miss(miss), .locked(locked), .valid_count(valid_count), .miss_count(miss_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model state ----------------
  int cyc = 0;
  bit m_en;
  bit m_armed;
  int m_dcyc;
  int m_streak;
  int m_last_err;
  bit m_last_sat;
  int m_nvalid;
  int m_nmiss;
  logic [1:0] m_mode;

  // Scoreboard entry: {err_valid, miss, saturated, locked, phase_error}
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_got, mon_exp;
  int obs_valid = 0;
  int obs_miss  = 0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input bit v, input bit m, input bit s,
                                         input bit l, input int e);
    logic [ERR_W-1:0] es;
    es = e[ERR_W-1:0];
    return {v, m, s, l, es};
  endfunction

  function automatic void model_data();
    if (m_en) begin
      m_armed = 1'b1;
      m_dcyc  = cyc;
    end
  endfunction

  function automatic void model_ref();
    int delta;
    int e;
    bit sat;
    if (!m_en) return;
    if (m_armed) begin
      delta = (cyc - m_dcyc) % (1 << CNT_W);
      e     = delta - EXP_D;
      m_streak = ((e <= LOCK_WIN) && (e >= -LOCK_WIN)) ? m_streak + 1 : 0;
      sat = 1'b0;
      if (e > ERR_HI) begin e = ERR_HI; sat = 1'b1; end
      else if (e < ERR_LO) begin e = ERR_LO; sat = 1'b1; end
      m_last_err = e;
      m_last_sat = sat;
      m_armed    = 1'b0;
      m_nvalid++;
      exp_q.push_back(pack(1'b1, 1'b0, sat, m_streak >= LOCK_CNT, e));
    end else begin
      m_streak = 0;
      m_nmiss++;
      exp_q.push_back(pack(1'b0, 1'b1, m_last_sat, 1'b0, m_last_err));
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && (err_valid || miss)) begin
      if (err_valid) obs_valid++;
      if (miss) obs_miss++;
      mon_got = {err_valid, miss, saturated, locked, phase_error};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got %b expected no strobe", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard: got %b expected %b", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drive_d(input logic v);
    bit q;
    if (v !== d_in) begin
      case (m_mode)
        2'b01:   q = !v;
        2'b10:   q = 1'b1;
        default: q = v;
      endcase
      d_in = v;
      if (q) model_data();
    end
  endtask

  task automatic drive_r(input logic v);
    if (v && !recovered_clk) model_ref();
    recovered_clk = v;
  endtask

  task automatic drive_mode(input logic [1:0] v);
    edge_mode = v;
    m_mode    = v;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    m_en   = v;
    if (!v) begin
      m_armed  = 1'b0;
      m_streak = 0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
    m_armed = 1'b0; m_streak = 0; m_last_err = 0; m_last_sat = 1'b0;
    m_nvalid = 0; m_nmiss = 0;
    exp_q.delete();
  endtask

  // Produce one edge that qualifies under the current mode.
  task automatic data_edge();
    case (m_mode)
      2'b01:   begin if (!d_in) begin drive_d(1'b1); step(1); end drive_d(1'b0); end
      2'b10:   drive_d(~d_in);
      default: begin if (d_in) begin drive_d(1'b0); step(1); end drive_d(1'b1); end
    endcase
  endtask

  task automatic ref_pulse();
    drive_r(1'b1);
    step(1);
    drive_r(1'b0);
    step(6);
  endtask

  task automatic measure(input int gap);
    data_edge();
    if (gap > 0) step(gap);
    ref_pulse();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int         gap;
    logic [1:0] mode;
    int         exp_err;
    bit         exp_sat;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    int base_v, base_m;

    vecs[0] = '{5,   2'b00,  0, 1'b0};
    vecs[1] = '{9,   2'b00,  4, 1'b0};
    vecs[2] = '{2,   2'b00, -3, 1'b0};
    vecs[3] = '{100, 2'b00, 31, 1'b1};
    vecs[4] = '{0,   2'b00, -5, 1'b0};
    vecs[5] = '{265, 2'b00,  4, 1'b0};
    vecs[6] = '{7,   2'b01,  2, 1'b0};
    vecs[7] = '{5,   2'b10,  0, 1'b0};
    vecs[8] = '{3,   2'b11, -2, 1'b0};
    vecs[9] = '{4,   2'b10, -1, 1'b0};

    d_in = 1'b0; recovered_clk = 1'b0;
    drive_mode(2'b00);
    set_enable(1'b1);
    do_reset(3);

    // Reset state
    check("rst_phase_error", phase_error, 0);
    check("rst_saturated",   saturated,   0);
    check("rst_err_valid",   err_valid,   0);
    check("rst_miss",        miss,        0);
    check("rst_locked",      locked,      0);
    check("rst_valid_count", valid_count, 0);
    check("rst_miss_count",  miss_count,  0);
    step(4);

    // Pin-to-output latency: err_valid appears SYNC+1 cycles after the ref pin rises
    data_edge();
    step(5);
    drive_r(1'b1);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 1) drive_r(1'b0);
      if (err_valid && (k == 0)) k = i;
    end
    check("latency", k, SYNC + 1);
    check("latency_err", phase_error, 0);

    // Table-driven measurements
    for (int i = 0; i < 10; i++) begin
      drive_mode(vecs[i].mode);
      step(2);
      measure(vecs[i].gap);
      check($sformatf("vec%0d_err", i), phase_error, vecs[i].exp_err);
      check($sformatf("vec%0d_sat", i), saturated, int'(vecs[i].exp_sat));
    end

    // A second ref edge with only one data edge gives a miss and holds the error
    drive_mode(2'b00);
    drive_d(1'b0);
    step(4);
    base_m = obs_miss;
    measure(9);
    ref_pulse();
    check("miss_count_obs", obs_miss - base_m, 1);
    check("miss_held_err", phase_error, 4);

    // Falling-edge mode ignores the rise and measures from the fall
    drive_mode(2'b01);
    step(2);
    drive_d(1'b1);
    step(3);
    drive_d(1'b0);
    step(5);
    ref_pulse();
    check("mode01_from_fall", phase_error, 0);
    base_m = obs_miss;
    drive_d(1'b1);
    step(5);
    ref_pulse();
    check("mode01_rise_ignored", obs_miss - base_m, 1);

    // Both-edges mode re-arms on the later edge
    drive_mode(2'b10);
    step(2);
    drive_d(1'b0);
    step(4);
    drive_d(1'b1);
    step(6);
    ref_pulse();
    check("mode10_rearm", phase_error, 1);

    // Lock acquisition, loss, and clear on enable low
    drive_mode(2'b00);
    step(2);
    ref_pulse();
    for (int i = 0; i < LOCK_CNT; i++) begin
      measure(5);
      check($sformatf("lock_step%0d", i), locked, int'(i == LOCK_CNT - 1));
    end
    measure(8);
    check("lock_lost_err", phase_error, 3);
    check("lock_lost", locked, 0);
    for (int i = 0; i < LOCK_CNT; i++) measure(4 + (i % 3));
    check("relock", locked, 1);
    set_enable(1'b0);
    step(2);
    check("enable_low_unlock", locked, 0);
    base_v = obs_valid;
    base_m = obs_miss;
    measure(5);
    ref_pulse();
    check("enable_low_no_valid", obs_valid - base_v, 0);
    check("enable_low_no_miss",  obs_miss - base_m, 0);
    check("enable_low_err_held", phase_error, 0);
    set_enable(1'b1);
    step(3);

    // Reset while armed clears outputs; next ref edge is a miss
    measure(9);
    drive_d(1'b0);
    step(2);
    drive_d(1'b1);
    step(4);
    drive_d(1'b0);
    step(5);
    do_reset(1);
    check("rst2_phase_error", phase_error, 0);
    check("rst2_saturated",   saturated,   0);
    check("rst2_locked",      locked,      0);
    check("rst2_valid_count", valid_count, 0);
    check("rst2_miss_count",  miss_count,  0);
    step(4);
    base_m = obs_miss;
    ref_pulse();
    check("rst2_next_is_miss", obs_miss - base_m, 1);

    // Randomised pin activity against the event model
    for (int i = 0; i < 400; i++) begin
      int a;
      a = $urandom_range(0, 19);
      if (a == 0) begin
        step(6); drive_mode(2'($urandom_range(0, 3))); step(6);
      end else if (a == 1) begin
        step(6); set_enable(!enable); step(6);
      end else if (a < 9) begin
        drive_d(~d_in);
      end else if (a < 16) begin
        drive_r(~recovered_clk);
      end else begin
        drive_d(~d_in);
        drive_r(1'b1);
      end
      if ($urandom_range(0, 9) == 0) step($urandom_range(30, 150));
      else step($urandom_range(1, 10));
    end
    step(10);
    if (!enable) set_enable(1'b1);
    step(4);
    check("drain_empty", exp_q.size(), 0);

`ifdef TDC_PD_STATS_EN
    check("stats_valid", valid_count, m_nvalid);
    check("stats_miss",  miss_count,  m_nmiss);
`else
    check("stats_valid_tied", valid_count, 0);
    check("stats_miss_tied",  miss_count,  0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_phase_detector.md
# tdc_phase_detector

Parametrised counter-based (TDC-style) phase detector for the CDR loop. Measures clk-cycle distance from a selected d_in transition to the next recovered_clk rising edge, subtracts a configurable expected delay, and emits a saturated signed error with a valid strobe. Adds miss detection and lock indication. Drives the loop filter in place of the fixed 4-bit detector.

## Interface
- CNT_W, 8 — timestamp counter width (≥4)
- ERR_W, 6 — signed phase_error width (2..CNT_W+1)
- EXPECTED_DELAY, 5 — delta giving zero error (< 2^CNT_W)
- SYNC_STAGES, 2 — synchroniser depth per async input (≥2)
- LOCK_WIN, 1 — |error| ≤ LOCK_WIN counts as in-window
- LOCK_CNT, 8 — consecutive in-window samples required for lock (≥1)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  measurement enable
- d_in  in  1  async data input
- recovered_clk  in  1  async recovered clock
- edge_mode  in  2  d_in edge select: 00 rising, 01 falling, 10 both, 11 rising
- phase_error  out  ERR_W  signed error, held between updates
- err_valid  out  1  one-cycle pulse per new phase_error
- saturated  out  1  phase_error was clipped; updates with err_valid
- miss  out  1  one-cycle pulse: recovered_clk edge with no data edge armed
- locked  out  1  lock indicator
- valid_count  out  16  stats (see Configuration)
- miss_count  out  16  stats (see Configuration)

## Operation
- d_in and recovered_clk each pass SYNC_STAGES flops; edges are detected on the last stage against a one-cycle-delayed copy.
- Free-running CNT_W counter increments every clk; wraps modulo 2^CNT_W.
- States: IDLE (no timestamp held), ARMED (timestamp held).
- Data edge (per edge_mode, enable=1): d_time ← cnt; → ARMED (re-arms and overwrites when already ARMED).
- Ref edge in ARMED: delta = (cnt − d_time) mod 2^CNT_W; err = delta − EXPECTED_DELAY in CNT_W+1 signed; clamp to [−2^(ERR_W−1), 2^(ERR_W−1)−1]; saturated=1 iff clamped; err_valid pulse; → IDLE.
- Ref edge in IDLE: miss pulse; phase_error/saturated hold; state stays IDLE.
- Data and ref edge in same cycle: data edge takes precedence → delta=0 measurement, err=−EXPECTED_DELAY; → IDLE.
- Lock: counter increments on each err_valid with |err| ≤ LOCK_WIN (pre-clamp value), saturating at LOCK_CNT; locked=1 while counter=LOCK_CNT. Out-of-window sample or miss clears counter and locked.
- enable=0: state forced to IDLE, no err_valid/miss, lock counter and locked cleared; synchronisers and counter keep running; phase_error holds.

## Timing
- Reset (sync): cnt, d_time, synchronisers, phase_error, saturated, err_valid, miss, locked, lock counter, stats counters all 0; state IDLE.
- Edge detect is combinational on the last sync stage; phase_error, saturated, err_valid, miss, locked register on that clk edge, visible the next cycle.
- Pin-to-output latency: SYNC_STAGES+1 clk cycles; delta is measured between synchronised edges, so equal latency cancels.
- locked rises the cycle after the LOCK_CNT-th in-window err_valid; falls the cycle after the disqualifying event.
- Delta > 2^CNT_W−1 cycles aliases (wrap); not flagged.

## Configuration
- TDC_PD_STATS_EN defined: valid_count increments per err_valid, miss_count per miss; both saturate at 16'hFFFF; cleared by reset only.
- Undefined: no stats logic; valid_count and miss_count tied to 0.

## Test plan
- Defaults, edge_mode=00: d_in rise, recovered_clk rise 5 clk later → phase_error=0, err_valid single pulse, saturated=0; 9 later → +4; 2 later → −3.
- Saturation: ref edge 100 cycles after data edge → phase_error=+31, saturated=1; coincident edges → −5, saturated=0.
- Wrap: data edge captured at cnt=250, ref edge at cnt=3 → delta 9, phase_error=+4.
- Miss/modes: two ref edges, one data edge → second gives miss pulse, phase_error held; edge_mode=01 ignores d_in rise, measures from fall; 10 measures from both.
- Lock: 8 consecutive errors of 0 → locked=1 after 8th; next error +3 → locked=0; enable low mid-run clears lock, no pulses.
- Reset asserted one cycle while ARMED → all outputs 0, next ref edge gives miss; with TDC_PD_STATS_EN, counters match pulse counts over 20 edges.
